// File: rtl/simd_merge_param_if.sv
// Request/result bundle for the streaming merge unit: operands and tags in,
// merged halves, tags and source-consumption report out.
interface simd_merge_param_if #(
    parameter int LANES = 8,
    parameter int DW    = 32
);
    logic                      in_v;
    logic [4:0]                rd;
    logic [2:0]                vrd1, vrd2;
    logic                      desc;
    logic [LANES-1:0][DW-1:0]  in_a, in_b;
    logic                      busy, drop, out_v;
    logic [LANES-1:0][DW-1:0]  out_first, out_last;
    logic [4:0]                out_rd;
    logic [2:0]                out_vrd1, out_vrd2;
    logic                      next_src_v, next_src, next_both;

    modport master (
        output in_v, rd, vrd1, vrd2, desc, in_a, in_b,
        input  busy, drop, out_v, out_first, out_last, out_rd, out_vrd1, out_vrd2,
               next_src_v, next_src, next_both
    );
    modport slave (
        input  in_v, rd, vrd1, vrd2, desc, in_a, in_b,
        output busy, drop, out_v, out_first, out_last, out_rd, out_vrd1, out_vrd2,
               next_src_v, next_src, next_both
    );
endinterface

// File: rtl/simd_merge_param.sv
// Streaming merge of two sorted LANES-wide vectors through a registered Batcher
// odd-even merge network, keeping the upper half as residue for the next op.
module simd_merge_cell #(
    parameter int DW     = 32,
    parameter int SIGNED = 0,
    parameter int HIGH   = 0
) (
    input  logic          clk,
    input  logic          desc,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    output logic [DW-1:0] q
);
    logic lt, take_x;
    assign lt     = (SIGNED != 0) ? ($signed(x) < $signed(y)) : (x < y);
    // low side keeps the min (ascending) or max (descending); high side the opposite
    assign take_x = lt ^ desc ^ (HIGH != 0);

    always_ff @(posedge clk) q <= take_x ? x : y;
endmodule

module simd_merge_param #(
    parameter int LANES  = 8,
    parameter int DW     = 32,
    parameter int SIGNED = 0
) (
    input logic clk,
    input logic reset,
    simd_merge_param_if.slave io
);
    localparam int N2 = 2 * LANES;
    localparam int S  = $clog2(N2);

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] vrd1;
        logic [2:0] vrd2;
    } tag_t;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    // Comparator partner of element e in the stage with distance k; -1 = pass
    function automatic int cas_partner(int k, int e);
        int m, r, j;
        if (k == LANES) return (e < k) ? e + k : e - k;
        if (e < k) return -1;
        m = e - k;
        r = m % (2 * k);
        j = e - r;
        if (j > N2 - 1 - k) return -1;
        return (r < k) ? e + k : e - k;
    endfunction

    function automatic logic lt_f(logic [DW-1:0] x, logic [DW-1:0] y);
        return (SIGNED != 0) ? ($signed(x) < $signed(y)) : (x < y);
    endfunction

    state_t                  state, state_n;
    logic [N2-1:0][DW-1:0]   net [S+1];
    logic [N2-1:0][DW-1:0]   in_reg;
    logic [LANES-1:0][DW-1:0] residue;
    logic [S:0]              vld_pipe;
    tag_t [S:0]              tag_pipe;
    tag_t                    tag_in;
    logic                    desc_q, last_q, busy, accept, pick_a;
    logic                    drop, next_src_v, next_src, next_both;

    assign busy   = (state == RUN);
    assign accept = io.in_v && !busy && !reset;
    // ties go to in_b
    assign pick_a = desc_q ? lt_f(io.in_b[0], io.in_a[0]) : lt_f(io.in_a[0], io.in_b[0]);
    assign tag_in = accept ? {io.rd, io.vrd1, io.vrd2} : '0;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = RUN;
            HOLD:    if (accept) state_n = RUN;
            RUN:     if (vld_pipe[S]) state_n = last_q ? IDLE : HOLD;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            vld_pipe   <= '0;
            tag_pipe   <= '0;
            drop       <= 1'b0;
            next_src_v <= 1'b0;
            next_src   <= 1'b0;
            next_both  <= 1'b0;
            desc_q     <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state      <= state_n;
            vld_pipe   <= {vld_pipe[S-1:0], accept};
            tag_pipe   <= {tag_pipe[S-1:0], tag_in};
            drop       <= io.in_v && busy;
            next_src_v <= accept;
            if (accept) begin
                last_q <= (io.rd == 5'd0);
                if (state == IDLE) begin
                    desc_q    <= io.desc;
                    next_src  <= 1'b0;
                    next_both <= 1'b1;
                end else begin
                    next_src  <= !pick_a;
                    next_both <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            in_reg <= (state == IDLE) ? {io.in_b, io.in_a}
                                      : {residue, (pick_a ? io.in_a : io.in_b)};
        if (vld_pipe[S] && !last_q)
            residue <= net[S][N2-1:LANES];
    end

    assign net[0] = in_reg;

    // pass-through lanes use a cell whose two inputs are the same element
    for (genvar s = 0; s < S; s++) begin : g_stage
        for (genvar e = 0; e < N2; e++) begin : g_lane
            localparam int P = cas_partner(LANES >> s, e);
            localparam int Q = (P < 0) ? e : P;
            simd_merge_cell #(.DW(DW), .SIGNED(SIGNED), .HIGH((P >= 0 && P < e) ? 1 : 0)) u_cell (
                .clk  (clk),
                .desc (desc_q),
                .x    (net[s][e]),
                .y    (net[s][Q]),
                .q    (net[s+1][e])
            );
        end
    end

    assign io.busy       = busy;
    assign io.drop       = drop;
    assign io.out_v      = vld_pipe[S];
    assign io.out_first  = net[S][LANES-1:0];
    assign io.out_last   = net[S][N2-1:LANES];
    assign io.out_rd     = tag_pipe[S].rd;
    assign io.out_vrd1   = tag_pipe[S].vrd1;
    assign io.out_vrd2   = tag_pipe[S].vrd2;
    assign io.next_src_v = next_src_v;
    assign io.next_src   = next_src;
    assign io.next_both  = next_both;
endmodule

// File: tb/tb_simd_merge_param.sv
// Bench for simd_merge_param: table of 8-lane ops checked through a scoreboard,
// plus drop, reset-abort and 4-lane signed/unsigned descending sequences.
module tb_simd_merge_param;
    localparam int L8 = 5;

    typedef logic [7:0][31:0] v8_t;
    typedef struct {
        v8_t a, b;
        logic [4:0] rd;
        logic [2:0] v1, v2;
        bit d;
        v8_t ef, el;
        bit ns, nb;
    } rec_t;
    typedef struct {
        v8_t ef, el;
        logic [4:0] rd;
        logic [2:0] v1, v2;
        int cyc;
    } exp_t;

    logic clk = 0, reset = 1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    exp_t sbq[$];
    exp_t mon_e;
    rec_t tbl[8];
    v8_t m_res;
    bit m_has = 0, m_desc = 0;

    simd_merge_param_if #(.LANES(8), .DW(32)) io8();
    simd_merge_param_if #(.LANES(4), .DW(8))  io4s();
    simd_merge_param_if #(.LANES(4), .DW(8))  io4u();

    simd_merge_param #(.LANES(8), .DW(32), .SIGNED(0)) dut8  (.clk(clk), .reset(reset), .io(io8.slave));
    simd_merge_param #(.LANES(4), .DW(8),  .SIGNED(1)) dut4s (.clk(clk), .reset(reset), .io(io4s.slave));
    simd_merge_param #(.LANES(4), .DW(8),  .SIGNED(0)) dut4u (.clk(clk), .reset(reset), .io(io4u.slave));

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic v8_t sorted8(v8_t v, bit d);
        logic [31:0] t;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 7 - i; j++)
                if (d ? (v[j] < v[j+1]) : (v[j] > v[j+1])) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        return v;
    endfunction

    function automatic void merge16(v8_t p, v8_t q, bit d, output v8_t f, output v8_t l);
        logic [31:0] arr [16];
        logic [31:0] t;
        for (int i = 0; i < 8; i++) begin arr[i] = p[i]; arr[i+8] = q[i]; end
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 15 - i; j++)
                if (d ? (arr[j] < arr[j+1]) : (arr[j] > arr[j+1])) begin
                    t = arr[j]; arr[j] = arr[j+1]; arr[j+1] = t;
                end
        for (int i = 0; i < 8; i++) begin f[i] = arr[i]; l[i] = arr[i+8]; end
    endfunction

    // reference: head pick against the residue, then a full sort of the 16 keys
    task automatic model(inout rec_t r);
        v8_t p, q;
        bit pa;
        if (!m_has) begin
            m_desc = r.d; p = r.a; q = r.b; r.nb = 1; r.ns = 0;
        end else begin
            pa = m_desc ? (r.b[0] < r.a[0]) : (r.a[0] < r.b[0]);
            p = pa ? r.a : r.b; q = m_res; r.nb = 0; r.ns = !pa;
        end
        merge16(p, q, m_desc, r.ef, r.el);
        m_has = (r.rd != 0);
        m_res = r.el;
    endtask

    task automatic do_op(input rec_t r);
        int n;
        exp_t e;
        n = 0;
        while (io8.busy === 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("busy_wait", n < 50, 1);
        io8.in_v = 1; io8.in_a = r.a; io8.in_b = r.b; io8.rd = r.rd;
        io8.vrd1 = r.v1; io8.vrd2 = r.v2; io8.desc = r.d;
        @(negedge clk);
        io8.in_v = 0;
        e.ef = r.ef; e.el = r.el; e.rd = r.rd; e.v1 = r.v1; e.v2 = r.v2; e.cyc = cyc + L8 - 1;
        sbq.push_back(e);
        chk("next_src_v", io8.next_src_v, 1);
        chk("busy_t1", io8.busy, 1);
        chk("drop_idle", io8.drop, 0);
        chk("next_both", io8.next_both, r.nb);
        if (!r.nb) chk("next_src", io8.next_src, r.ns);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 40) begin @(negedge clk); n++; end
        chk("sb_drain", sbq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!reset && io8.out_v === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out_v cyc=%0d", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("out_first", io8.out_first, mon_e.ef);
                chk("out_last", io8.out_last, mon_e.el);
                chk("out_rd", io8.out_rd, mon_e.rd);
                chk("out_vrd1", io8.out_vrd1, mon_e.v1);
                chk("out_vrd2", io8.out_vrd2, mon_e.v2);
                chk("out_cycle", cyc, mon_e.cyc);
                chk("busy_tL", io8.busy, 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        rec_t r;
        int k;
        io8.in_v = 0; io8.rd = 0; io8.vrd1 = 0; io8.vrd2 = 0; io8.desc = 0; io8.in_a = '0; io8.in_b = '0;
        io4s.in_v = 0; io4s.rd = 0; io4s.vrd1 = 0; io4s.vrd2 = 0; io4s.desc = 0; io4s.in_a = '0; io4s.in_b = '0;
        io4u.in_v = 0; io4u.rd = 0; io4u.vrd1 = 0; io4u.vrd2 = 0; io4u.desc = 0; io4u.in_a = '0; io4u.in_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", io8.busy, 0);
        chk("rst_drop", io8.drop, 0);
        chk("rst_out_v", io8.out_v, 0);
        chk("rst_nsv", io8.next_src_v, 0);
        chk("rst_ns_nb", {io8.next_src, io8.next_both}, 0);
        chk("rst_tags", {io8.out_rd, io8.out_vrd1, io8.out_vrd2}, 0);
        reset = 0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            tbl[i].v1 = 3'(i); tbl[i].v2 = 3'(7 - i); tbl[i].d = 0;
        end
        for (int j = 0; j < 8; j++) begin
            tbl[0].a[j] = 2 * j;       tbl[0].b[j] = 2 * j + 1;
            tbl[1].a[j] = 16 + j;      tbl[1].b[j] = 24 + j;
            tbl[2].a[j] = 40 + j;      tbl[2].b[j] = 24 + j;
            for (int t = 3; t < 6; t++) begin
                tbl[t].a[j] = $urandom_range(0, 200);
                tbl[t].b[j] = $urandom_range(0, 200);
            end
            tbl[6].a[j] = (j < 4) ? 32'(j) : 32'hFFFF_FFFC + 32'(j - 4);
            tbl[6].b[j] = 32'h8000_0000 + 32'(j);
            tbl[7].a[j] = 32'h8000_0010 + 32'(j);
            tbl[7].b[j] = 32'hFFFF_FFF0 + 32'(j);
        end
        for (int t = 3; t < 6; t++) begin
            tbl[t].a = sorted8(tbl[t].a, 1);
            tbl[t].b = sorted8(tbl[t].b, 1);
        end
        tbl[5].a[0] = 250; tbl[5].b[0] = 250;
        tbl[3].d = 1;
        tbl[0].rd = 5; tbl[1].rd = 7; tbl[2].rd = 0; tbl[3].rd = 3;
        tbl[4].rd = 9; tbl[5].rd = 0; tbl[6].rd = 1; tbl[7].rd = 0;
        for (int i = 0; i < 8; i++) model(tbl[i]);

        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i]);
            if (i == 0) begin
                // rejected requests mid-op and in the out_v cycle
                @(negedge clk);
                io8.in_v = 1; io8.in_a = '1; io8.rd = 5'd0;
                @(negedge clk);
                io8.in_v = 0;
                chk("drop_t3", io8.drop, 1);
                chk("nsv_after_drop", io8.next_src_v, 0);
                @(negedge clk);
                chk("drop_t4", io8.drop, 0);
                @(negedge clk);
                io8.in_v = 1;
                @(negedge clk);
                io8.in_v = 0;
                chk("drop_t6", io8.drop, 1);
                chk("busy_t6", io8.busy, 0);
            end
        end
        drain();

        // reset in the middle of an op abandons it and discards the residue
        for (int j = 0; j < 8; j++) begin r.a[j] = 3 * j; r.b[j] = 3 * j + 1; end
        r.rd = 4; r.v1 = 1; r.v2 = 1; r.d = 0;
        model(r);
        do_op(r);
        void'(sbq.pop_back());
        @(negedge clk);
        reset = 1; io8.in_v = 1;
        repeat (2) @(negedge clk);
        chk("busy_in_rst", io8.busy, 0);
        reset = 0; io8.in_v = 0;
        @(negedge clk);
        chk("busy_after_rst", io8.busy, 0);
        chk("nsv_after_rst", io8.next_src_v, 0);
        repeat (L8 + 2) @(negedge clk);
        m_has = 0;
        for (int j = 0; j < 8; j++) begin r.a[j] = 100 + j; r.b[j] = 50 + 2 * j; end
        r.rd = 0; r.v1 = 6; r.v2 = 2;
        model(r);
        do_op(r);
        drain();

        // 4-lane descending, signed vs unsigned ordering of the same bit patterns
        io4s.in_a = {8'hF8, 8'hFF, 8'h03, 8'h07};
        io4s.in_b = {8'hF7, 8'hFE, 8'h00, 8'h05};
        io4u.in_a = {8'h03, 8'h07, 8'hF8, 8'hFF};
        io4u.in_b = {8'h00, 8'h05, 8'hF7, 8'hFE};
        io4s.desc = 1; io4u.desc = 1; io4s.rd = 2; io4u.rd = 2;
        io4s.in_v = 1; io4u.in_v = 1;
        @(negedge clk);
        io4s.in_v = 0; io4u.in_v = 0;
        k = 1;
        while (io4s.out_v !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        chk("l4_latency", k, 4);
        chk("l4s_first", io4s.out_first, {8'h00, 8'h03, 8'h05, 8'h07});
        chk("l4s_last", io4s.out_last, {8'hF7, 8'hF8, 8'hFE, 8'hFF});
        chk("l4s_rd", io4s.out_rd, 2);
        chk("l4u_out_v", io4u.out_v, 1);
        chk("l4u_first", io4u.out_first, {8'hF7, 8'hF8, 8'hFE, 8'hFF});
        chk("l4u_last", io4u.out_last, {8'h00, 8'h03, 8'h05, 8'h07});
        @(negedge clk);
        chk("l4s_pulse", io4s.out_v, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/simd_merge_param.md
# simd_merge_param

Parametrised, signed/unsigned, ascending/descending streaming merge unit for the custom SIMD path. It merges two sorted LANES-wide vectors through a registered odd-even merge network. It keeps the upper LANES results as residue, so that long sorted streams are merged one vector per operation, and it reports which source vector was consumed. It sits beside the sorter and prefix-sum units in the custom-instruction execute stage and returns results with destination tags (rd, vrd1, vrd2).

## Interface
- LANES, 8, elements per vector; power of two, 2..16
- DW, 32, element width in bits
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_v  in  1  operation request
- rd  in  5  scalar destination tag; rd==0 marks last op of a sequence
- vrd1, vrd2  in  3 each  vector destination tags
- desc  in  1  1 = descending order; sampled only on a sequence's first op
- in_a, in_b  in  LANES*DW  sorted source vectors, element k at [DW*(k+1)-1 -: DW]
- busy  out  1  op in flight; in_v ignored while high
- drop  out  1  one-cycle pulse when in_v arrives while busy
- out_v  out  1  result valid, one-cycle pulse
- out_first, out_last  out  LANES*DW each  first/last LANES elements of merged 2*LANES in sort order
- out_rd, out_vrd1, out_vrd2  out  5/3/3  tags aligned with out_v
- next_src_v  out  1  one-cycle pulse, source-consumption report valid
- next_src  out  1  0 = in_a consumed, 1 = in_b consumed
- next_both  out  1  both sources consumed (sequence first op)

## Operation
- Network: 2*LANES-input Batcher odd-even merge, S = log2(2*LANES) CAS stages, each stage registered. Pass-through lanes are registered too.
- CAS compare direction follows latched desc. Lane ordering is signed or unsigned per SIGNED.
- The input register (first_half, second_half) is one stage, so latency L = S+1 (8 lanes: L=5).
- States:
  - IDLE: no residue.
  - RUN: op in flight.
  - HOLD: residue valid, accepting.
- Accept = in_v && !busy.
- Accept in IDLE:
  - first_half = in_a, second_half = in_b; latch desc; next_both=1.
  - Go to RUN.
- Accept in HOLD:
  - Head compare on lane 0: pick_a = in_a[0] < in_b[0] (ascending) or in_a[0] > in_b[0] (descending). Ties pick in_b.
  - first_half = picked vector, second_half = residue.
  - next_src = !pick_a, next_both=0.
  - Go to RUN.
- RUN → HOLD when out_v: residue ← out_last. If the op carried rd==0, go RUN → IDLE instead and discard the residue.
- next_src_v pulses the cycle after accept. next_src and next_both are held until the next pulse.
- Tags are shifted alongside valid and emerge with out_v.
- drop pulses the cycle after any in_v rejected by busy. A rejected op has no other effect.
- Element values pass unmodified; no arithmetic beyond compare. Equal keys are both kept; the merge is not required to be stable.

## Timing
- Accept sampled at edge t.
- busy=1 for cycles t+1..t+L. busy=0 at t+L+1, which is the earliest next accept.
- out_v=1 in cycle t+L only. out_first, out_last and the tags are valid that cycle.
- in_v at cycle t+L is dropped. in_v at t+L+1 uses the new residue.
- Reset values: busy, drop, out_v, next_src_v, next_src, next_both, out_rd, out_vrd1, out_vrd2 = 0. State = IDLE, desc latch = 0, network contents don't-care.
- Reset mid-operation: in-flight op is abandoned with no out_v, residue is discarded, and the block is accepting one cycle after reset falls.
- in_v with reset high is ignored.
- Throughput: one op per L+1 cycles (not pipelined, due to residue feedback).

## Test plan
- LANES=8 ascending: op1 A={0,2,..,14}, B={1,3,..,15}, rd=5 → cycle t+5 out_first={0..7}, out_last={8..15}, next_both=1, out_rd=5, busy high t+1..t+5.
- Continue (HOLD), op at t+6: A={16..23}, B={24..31} → pick A, next_src=0 at t+7; out_first={8..15}, out_last={16..23} at t+11.
- Back-to-back violation: in_v at t+2 and t+5 of a running op → drop pulses at t+3 and t+6; results and residue unchanged.
- Sequence end: op with rd=0 → normal out_v. The next op behaves as a first op (next_both=1, in_a/in_b both loaded), proving the residue was discarded.
- desc=1, LANES=4, SIGNED=1: A={7,3,-1,-8}, B={5,0,-2,-9} → out_first={7,5,3,0}, out_last={-1,-2,-8,-9}. With SIGNED=0 the same bits order negatives first.
- Reset asserted at t+3 of an op → no out_v. busy=0 after reset. Next op is treated as a first op.
